// File: rtl/ara_wbeat_serializer.sv
// Snoops the VLSU AXI W channel and replays each accepted beat as a
// stream of its strobed bytes, lowest lane first, through a small FIFO.
module ara_wbeat_serializer #(
    parameter int unsigned DataWidth = 128,
    parameter int unsigned Depth     = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic [DataWidth-1:0]   w_data_i,
    input  logic [DataWidth/8-1:0] w_strb_i,
    input  logic                   w_valid_i,
    input  logic                   w_ready_i,
    output logic [7:0]             byte_o,
    output logic                   byte_valid_o,
    input  logic                   byte_ready_i,
    output logic                   overflow_o,
    output logic [31:0]            drop_cnt_o,
    output logic                   busy_o
);

    localparam int unsigned StrbW = DataWidth / 8;
    localparam int unsigned PtrW  = $clog2(Depth);
    localparam int unsigned IdxW  = $clog2(StrbW);
    localparam int unsigned CntW  = PtrW + 1;

    typedef logic [DataWidth-1:0] data_t;
    typedef logic [StrbW-1:0]     strb_t;

    data_t           data_q [Depth];
    data_t           data_d [Depth];
    strb_t           strb_q [Depth];
    strb_t           strb_d [Depth];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [PtrW-1:0] rptr_nxt;
    logic [CntW-1:0] cnt_q, cnt_d;
    strb_t           hs_q, hs_d;
    strb_t           hs_clr;
    logic            ovf_q, ovf_d;
    logic [31:0]     drop_q, drop_d;

    logic            cap;
    logic            empty;
    logic            full;
    logic            fire;
    logic            pop;
    logic            push;
    logic            drop;
    logic [IdxW-1:0] idx;
    data_t           head_data;

    // Lowest set bit of the working strobe selects the lane to emit.
    always_comb begin
        idx = '0;
        for (int i = StrbW - 1; i >= 0; i--) begin
            if (hs_q[i]) begin
                idx = IdxW'(i);
            end
        end
    end

    always_comb begin
        cap       = en_i & w_valid_i & w_ready_i & (|w_strb_i);
        empty     = (cnt_q == '0);
        full      = (cnt_q == CntW'(Depth));
        head_data = data_q[rptr_q];
        rptr_nxt  = rptr_q + PtrW'(1);
        hs_clr    = hs_q & ~(strb_t'(1) << idx);
        fire      = ~empty & byte_ready_i;
        pop       = fire & ~(|hs_clr);
        push      = cap & (~full | pop);
        drop      = cap & full & ~pop;
    end

    always_comb begin
        data_d = data_q;
        strb_d = strb_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        hs_d   = hs_q;
        ovf_d  = ovf_q;
        drop_d = drop_q;

        if (push) begin
            data_d[wptr_q] = w_data_i;
            strb_d[wptr_q] = w_strb_i;
            wptr_d         = wptr_q + PtrW'(1);
        end

        if (pop) begin
            rptr_d = rptr_nxt;
        end

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (fire) begin
            hs_d = hs_clr;
        end

        // With one entry left, a simultaneous push becomes the new head
        // before it is visible in the strobe array.
        if (pop) begin
            if (cnt_q > CntW'(1)) begin
                hs_d = strb_q[rptr_nxt];
            end else if (push) begin
                hs_d = w_strb_i;
            end else begin
                hs_d = '0;
            end
        end else if (push && empty) begin
            hs_d = w_strb_i;
        end

        if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 32'hFFFF_FFFF) begin
                drop_d = drop_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            hs_q   <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            hs_q   <= hs_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge clk_i) begin
        data_q <= data_d;
        strb_q <= strb_d;
    end

    assign byte_valid_o = ~empty;
    assign busy_o       = ~empty;
    assign byte_o       = empty ? 8'h00 : head_data[{idx, 3'b000} +: 8];
    assign overflow_o   = ovf_q;
    assign drop_cnt_o   = drop_q;

endmodule
